// File: rtl/multi_line_buffer_if.sv
// Pixel stream interface for the multi-row line buffer.
// The stream source owns sof/in_valid/in_data.
// The buffer owns the column outputs out_valid/out_col/out_x/out_eol.
interface multi_line_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_LINES  = 3
);
    logic                            sof;
    logic                            in_valid;
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            out_valid;
    logic [NUM_LINES*DATA_WIDTH-1:0] out_col;
    logic [ADDR_WIDTH-1:0]           out_x;
    logic                            out_eol;

    modport master (
        output sof, in_valid, in_data,
        input  out_valid, out_col, out_x, out_eol
    );

    modport slave (
        input  sof, in_valid, in_data,
        output out_valid, out_col, out_x, out_eol
    );
endinterface

// File: rtl/multi_line_buffer.sv
// Multi-row line buffer with rotating RAM banks.
// The last NUM_LINES-1 lines are held in NUM_LINES-1 banks.
// Each accepted pixel produces one vertical column of NUM_LINES pixels.
// The column appears one cycle after the pixel, once enough rows are primed.
module multi_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WIDTH = 640,
    parameter int NUM_LINES  = 3
) (
    input logic             clock,
    input logic             reset,
    multi_line_buffer_if.slave bus
);
    localparam int NB = NUM_LINES - 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = $clog2(NUM_LINES);
    localparam int DW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_X    = ADDR_WIDTH'(LINE_WIDTH - 1);
    localparam logic [RW-1:0]         PRIMED    = RW'(NUM_LINES - 1);
    localparam logic [BW-1:0]         LAST_BANK = BW'(NB - 1);

    // Write-side counters and their sof-overridden values for this cycle.
    logic [ADDR_WIDTH-1:0] col, col_eff;
    logic [RW-1:0]         row_cnt, row_eff;
    logic [BW-1:0]         wr_bank, bank_eff;

    // Stage-1 registers, aligned with the 1-cycle RAM read.
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [ADDR_WIDTH-1:0] x_p1;
    logic [BW-1:0]         bank_p1;

    logic [NB*DATA_WIDTH-1:0]        rd_bus;
    logic [NUM_LINES*DATA_WIDTH-1:0] col_mux;

    function automatic logic [BW-1:0] bank_next(input logic [BW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + BW'(1);
    endfunction

    function automatic logic [RW-1:0] row_next(input logic [RW-1:0] r);
        return (r == PRIMED) ? r : r + RW'(1);
    endfunction

    // A frame start makes this cycle behave as x=0, row=0, bank 0.
    always_comb begin
        col_eff  = bus.sof ? '0 : col;
        row_eff  = bus.sof ? '0 : row_cnt;
        bank_eff = bus.sof ? '0 : wr_bank;
    end

    // Raster position, row priming and bank rotation.
    always_ff @(posedge clock) begin
        if (reset) begin
            col     <= '0;
            row_cnt <= '0;
            wr_bank <= '0;
        end else if (bus.in_valid) begin
            if (col_eff == LAST_X) begin
                col     <= '0;
                wr_bank <= bank_next(bank_eff);
                row_cnt <= row_next(row_eff);
            end else begin
                col     <= col_eff + ADDR_WIDTH'(1);
                wr_bank <= bank_eff;
                row_cnt <= row_eff;
            end
        end else if (bus.sof) begin
            col     <= '0;
            row_cnt <= '0;
            wr_bank <= '0;
        end
    end

    // Stage p0 -> p1: register the pixel and its position alongside the RAM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            x_p1    <= '0;
            bank_p1 <= '0;
        end else begin
            vld_p1 <= bus.in_valid && (row_eff == PRIMED);
            if (bus.in_valid) begin
                data_p1 <= bus.in_data;
                x_p1    <= col_eff;
                bank_p1 <= bank_eff;
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [2**DW];
        logic [DATA_WIDTH-1:0] rd_p1;

        // Store the incoming pixel in the bank currently being filled.
        always_ff @(posedge clock) begin
            if (bus.in_valid && (bank_eff == BW'(b)))
                mem[col_eff[DW-1:0]] <= bus.in_data;
        end

        // Read the same address; a concurrent write returns the old row.
        always_ff @(posedge clock) begin
            if (reset)
                rd_p1 <= '0;
            else if (bus.in_valid)
                rd_p1 <= mem[col_eff[DW-1:0]];
        end

        assign rd_bus[b*DATA_WIDTH +: DATA_WIDTH] = rd_p1;
    end

    // Rotate bank outputs so slot 0 is the oldest row, then add the live pixel on top.
    always_comb begin
        col_mux = '0;
        for (int i = 0; i < NB; i++) begin
            int idx;
            idx = int'(bank_p1) + i;
            if (idx >= NB)
                idx = idx - NB;
            col_mux[i*DATA_WIDTH +: DATA_WIDTH] = rd_bus[idx*DATA_WIDTH +: DATA_WIDTH];
        end
        col_mux[NB*DATA_WIDTH +: DATA_WIDTH] = data_p1;
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_col   = col_mux;
    assign bus.out_x     = x_p1;
    assign bus.out_eol   = (x_p1 == LAST_X);
endmodule

// File: tb/tb_multi_line_buffer.sv
// Testbench for multi_line_buffer: 3 rows, 4-pixel lines, pixel value = row*16+x.
// Stimulus queues the expected column for each primed pixel.
// A monitor on the falling edge compares the column against the queue.
module tb_multi_line_buffer;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int LINE_WIDTH = 4;
    localparam int NUM_LINES  = 3;

    typedef struct {
        int          due;
        logic [47:0] col;
        logic [9:0]  x;
        logic        eol;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   gap_k  = 0;
    logic [31:0] gap_pat = 32'hA4C9_3265;
    exp_t q[$];

    multi_line_buffer_if #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_LINES(NUM_LINES)
    ) bus ();

    multi_line_buffer #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .LINE_WIDTH(LINE_WIDTH), .NUM_LINES(NUM_LINES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [47:0] exp_col(input int r, input int x);
        logic [15:0] s0, s1, s2;
        s0 = 16'((r - 2) * 16 + x);
        s1 = 16'((r - 1) * 16 + x);
        s2 = 16'(r * 16 + x);
        return {s2, s1, s0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        bus.sof      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic pix(input bit s, input int r, input int x);
        exp_t e;
        @(posedge clock);
        #1;
        bus.sof      = s;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(r * 16 + x);
        if (r >= 2) begin
            e.due = cyc + 1;
            e.col = exp_col(r, x);
            e.x   = 10'(x);
            e.eol = (x == LINE_WIDTH - 1);
            q.push_back(e);
        end
    endtask

    task automatic rows(input int r0, input int r1, input bit first_sof, input bit gaps);
        for (int r = r0; r <= r1; r++) begin
            for (int x = 0; x < LINE_WIDTH; x++) begin
                if (gaps) begin
                    if (gap_pat[gap_k % 32]) idle();
                    gap_k++;
                end
                pix(first_sof && (r == r0) && (x == 0), r, x);
            end
        end
    endtask

    // Compare outputs against the queue; with nothing due, out_valid must be low.
    always @(negedge clock) begin
        if (cyc > 0) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_col !== e.col ||
                    bus.out_x !== e.x || bus.out_eol !== e.eol) begin
                    errors++;
                    $display("FAIL column@%0d: got vld=%b col=%h x=%0d eol=%b expected vld=1 col=%h x=%0d eol=%b",
                             cyc, bus.out_valid, bus.out_col, bus.out_x, bus.out_eol,
                             e.col, e.x, e.eol);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_valid@%0d: got out_valid=%b expected 0", cyc, bus.out_valid);
                end
            end
        end
    end

    initial begin
        int budget;
        // Test 1: reset held with valid pixels presented.
        reset        = 1'b1;
        bus.sof      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0055;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("reset_valid", 64'(bus.out_valid), 64'd0);
            chk("reset_col",   64'(bus.out_col),   64'd0);
            chk("reset_x",     64'(bus.out_x),     64'd0);
            chk("reset_eol",   64'(bus.out_eol),   64'd0);
        end
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;

        // Tests 2 and 3: prime with rows 0..2, continue into row 3.
        rows(0, 2, 1'b1, 1'b0);
        rows(3, 3, 1'b0, 1'b0);
        idle();

        // Test 4: same frame with idle gaps.
        rows(0, 3, 1'b1, 1'b1);
        idle();

        // Test 5: frame restart part-way through row 2.
        rows(0, 1, 1'b1, 1'b0);
        pix(1'b0, 2, 0);
        pix(1'b0, 2, 1);
        rows(0, 2, 1'b1, 1'b0);
        idle();

        // Test 6: reset in row 3 at x=2, then restream.
        rows(0, 2, 1'b1, 1'b0);
        pix(1'b0, 3, 0);
        pix(1'b0, 3, 1);
        @(posedge clock);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0032;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("midreset_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset_x",     64'(bus.out_x),     64'd0);
        chk("midreset_col",   64'(bus.out_col),   64'd0);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        rows(0, 2, 1'b1, 1'b0);
        idle();

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d columns outstanding expected 0", q.size());
        end
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
